// File: rtl/core_pkg.sv
// Shared definitions for the five-stage RISC-V core: jump encodings,
// load/store funct3 sizes and the EX/MEM control bundle.
package core_pkg;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_JAL  = 2'b01;
    localparam logic [1:0] JUMP_JALR = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic [1:0] jump;
        logic       taken;
    } ex_mem_ctrl_t;

    localparam ex_mem_ctrl_t CTRL_BUBBLE = '{
        memread:  1'b0,
        memwrite: 1'b0,
        memtoreg: 1'b0,
        regwrite: 1'b0,
        jump:     JUMP_NONE,
        taken:    1'b0
    };

    // Control bundle an entry carries into MEM: real instructions keep theirs,
    // invalid entries never carry side-effecting controls.
    function automatic ex_mem_ctrl_t gate_ctrl(input ex_mem_ctrl_t ctrl, input logic valid);
        return valid ? ctrl : CTRL_BUBBLE;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic             w_full;

    assign w_full = &r_count;
    assign count  = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !w_full) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register with valid bit, stall/flush (rst > flush > stall > load)
// and saturating stall/bubble performance counters.
module exmem_pipe_reg
    import core_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      cnt_clr,
    input  logic                      ex_valid,
    input  logic [DATA_WIDTH-1:0]     ex_pc_plus_4,
    input  logic [DATA_WIDTH-1:0]     ex_pc_target,
    input  logic                      ex_taken,
    input  logic                      ex_memread,
    input  logic                      ex_memwrite,
    input  logic                      ex_memtoreg,
    input  logic                      ex_regwrite,
    input  logic [1:0]                ex_jump,
    input  logic [DATA_WIDTH-1:0]     ex_alu_result,
    input  logic [DATA_WIDTH-1:0]     ex_writedata,
    input  logic [2:0]                ex_funct3,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      mem_valid,
    output logic [DATA_WIDTH-1:0]     mem_pc_plus_4,
    output logic [DATA_WIDTH-1:0]     mem_pc_target,
    output logic                      mem_taken,
    output logic                      mem_memread,
    output logic                      mem_memwrite,
    output logic                      mem_memtoreg,
    output logic                      mem_regwrite,
    output logic [1:0]                mem_jump,
    output logic [DATA_WIDTH-1:0]     mem_alu_result,
    output logic [DATA_WIDTH-1:0]     mem_writedata,
    output logic [2:0]                mem_funct3,
    output logic [REG_ADDR_WIDTH-1:0] mem_rd,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      bubble_cnt
);

    logic                      r_valid;
    ex_mem_ctrl_t              r_ctrl;
    logic [DATA_WIDTH-1:0]     r_pc_plus_4;
    logic [DATA_WIDTH-1:0]     r_pc_target;
    logic [DATA_WIDTH-1:0]     r_alu_result;
    logic [DATA_WIDTH-1:0]     r_writedata;
    logic [2:0]                r_funct3;
    logic [REG_ADDR_WIDTH-1:0] r_rd;

    ex_mem_ctrl_t w_ex_ctrl;
    logic         w_load;
    logic         w_stall_evt;
    logic         w_bubble_evt;

    assign w_ex_ctrl = '{
        memread:  ex_memread,
        memwrite: ex_memwrite,
        memtoreg: ex_memtoreg,
        regwrite: ex_regwrite,
        jump:     ex_jump,
        taken:    ex_taken
    };

    assign w_load       = !flush && !stall;
    assign w_stall_evt  = stall && !flush;
    // A stalled invalid entry is not a new bubble; only flushes and fresh invalid loads count.
    assign w_bubble_evt = flush || (w_load && !ex_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_BUBBLE;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_BUBBLE;
        end else if (!stall) begin
            r_valid <= ex_valid;
            r_ctrl  <= gate_ctrl(w_ex_ctrl, ex_valid);
        end
    end

    // Data fields ignore flush so the clear stays off their wide enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_plus_4  <= '0;
            r_pc_target  <= '0;
            r_alu_result <= '0;
            r_writedata  <= '0;
            r_funct3     <= '0;
            r_rd         <= '0;
        end else if (w_load) begin
            r_pc_plus_4  <= ex_pc_plus_4;
            r_pc_target  <= ex_pc_target;
            r_alu_result <= ex_alu_result;
            r_writedata  <= ex_writedata;
            r_funct3     <= ex_funct3;
            r_rd         <= ex_rd;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (w_stall_evt),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (w_bubble_evt),
        .count (bubble_cnt)
    );

    assign mem_valid      = r_valid;
    assign mem_taken      = r_ctrl.taken;
    assign mem_memread    = r_ctrl.memread;
    assign mem_memwrite   = r_ctrl.memwrite;
    assign mem_memtoreg   = r_ctrl.memtoreg;
    assign mem_regwrite   = r_ctrl.regwrite;
    assign mem_jump       = r_ctrl.jump;
    assign mem_pc_plus_4  = r_pc_plus_4;
    assign mem_pc_target  = r_pc_target;
    assign mem_alu_result = r_alu_result;
    assign mem_writedata  = r_writedata;
    assign mem_funct3     = r_funct3;
    assign mem_rd         = r_rd;

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Directed bench for exmem_pipe_reg with 4-bit counters so saturation is reachable.
module tb_exmem_pipe_reg;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, stall, flush, cnt_clr;
    logic          ex_valid, ex_taken, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
    logic [DW-1:0] ex_pc_plus_4, ex_pc_target, ex_alu_result, ex_writedata;
    logic [1:0]    ex_jump;
    logic [2:0]    ex_funct3;
    logic [RW-1:0] ex_rd;

    logic          mem_valid, mem_taken, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
    logic [DW-1:0] mem_pc_plus_4, mem_pc_target, mem_alu_result, mem_writedata;
    logic [1:0]    mem_jump;
    logic [2:0]    mem_funct3;
    logic [RW-1:0] mem_rd;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    exmem_pipe_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .ex_valid(ex_valid), .ex_pc_plus_4(ex_pc_plus_4), .ex_pc_target(ex_pc_target),
        .ex_taken(ex_taken), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_jump(ex_jump),
        .ex_alu_result(ex_alu_result), .ex_writedata(ex_writedata),
        .ex_funct3(ex_funct3), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_pc_plus_4(mem_pc_plus_4), .mem_pc_target(mem_pc_target),
        .mem_taken(mem_taken), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite), .mem_jump(mem_jump),
        .mem_alu_result(mem_alu_result), .mem_writedata(mem_writedata),
        .mem_funct3(mem_funct3), .mem_rd(mem_rd),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling/driving.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {valid, taken, memread, memwrite, memtoreg, regwrite, jump}
    function automatic logic [31:0] ctrl_vec();
        return {24'd0, mem_valid, mem_taken, mem_memread, mem_memwrite,
                mem_memtoreg, mem_regwrite, mem_jump};
    endfunction

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        ex_valid = 1'b1; ex_taken = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b1;
        ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_jump = 2'b10;
        ex_pc_plus_4 = $urandom; ex_pc_target = $urandom;
        ex_alu_result = $urandom; ex_writedata = $urandom;
        ex_funct3 = 3'($urandom_range(0, 7)); ex_rd = 5'($urandom_range(1, 31));
        step(2);

        check("rst_ctrl", ctrl_vec(), 32'h0);
        check("rst_alu", mem_alu_result, 32'h0);
        check("rst_pc4", mem_pc_plus_4, 32'h0);
        check("rst_tgt", mem_pc_target, 32'h0);
        check("rst_wd", mem_writedata, 32'h0);
        check("rst_f3_rd", {24'd0, mem_funct3, mem_rd}, 32'h0);
        check("rst_cnts", {24'd0, stall_cnt, bubble_cnt}, 32'h0);

        // Plain valid load
        rst = 1'b0;
        ex_valid = 1'b1; ex_taken = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
        ex_memtoreg = 1'b0; ex_regwrite = 1'b1; ex_jump = 2'b00;
        ex_pc_plus_4 = 32'h104; ex_pc_target = 32'h200;
        ex_alu_result = 32'h0000_1234; ex_writedata = 32'hDEAD_BEEF;
        ex_funct3 = 3'b010; ex_rd = 5'd5;
        step();
        check("load_alu", mem_alu_result, 32'h1234);
        check("load_rd", {27'd0, mem_rd}, 32'd5);
        check("load_ctrl", ctrl_vec(), {24'd0, 8'b1000_0100});
        check("load_pc4", mem_pc_plus_4, 32'h104);
        check("load_wd", mem_writedata, 32'hDEAD_BEEF);
        check("load_cnts", {24'd0, stall_cnt, bubble_cnt}, 32'h0);

        // Stall holds contents for 3 cycles
        ex_alu_result = 32'hAAAA;
        step();
        check("pre_stall_alu", mem_alu_result, 32'hAAAA);
        stall = 1'b1; ex_alu_result = 32'hBBBB;
        step(3);
        check("stall_alu", mem_alu_result, 32'hAAAA);
        check("stall_valid", {31'd0, mem_valid}, 32'd1);
        check("stall_cnt3", {28'd0, stall_cnt}, 32'd3);
        stall = 1'b0;
        step();
        check("release_alu", mem_alu_result, 32'hBBBB);
        check("release_cnt", {28'd0, stall_cnt}, 32'd3);

        // Flush wins over simultaneous stall; data fields hold
        flush = 1'b1; stall = 1'b1;
        ex_memwrite = 1'b1; ex_taken = 1'b1; ex_alu_result = 32'hCCCC; ex_rd = 5'd9;
        step();
        check("flush_ctrl", ctrl_vec(), 32'h0);
        check("flush_alu", mem_alu_result, 32'hBBBB);
        check("flush_rd", {27'd0, mem_rd}, 32'd5);
        check("flush_bub", {28'd0, bubble_cnt}, 32'd1);
        check("flush_stc", {28'd0, stall_cnt}, 32'd3);
        flush = 1'b0; stall = 1'b0;

        // Invalid load: controls squashed, data still loads
        ex_valid = 1'b0; ex_regwrite = 1'b1; ex_jump = 2'b01;
        ex_memwrite = 1'b1; ex_taken = 1'b1; ex_memread = 1'b1;
        ex_alu_result = 32'h55;
        step();
        check("inv_ctrl", ctrl_vec(), 32'h0);
        check("inv_alu", mem_alu_result, 32'h55);
        check("inv_rd", {27'd0, mem_rd}, 32'd9);
        check("inv_bub", {28'd0, bubble_cnt}, 32'd2);

        // Held invalid entry is not a new bubble
        stall = 1'b1;
        step();
        check("held_inv_bub", {28'd0, bubble_cnt}, 32'd2);
        check("held_inv_stc", {28'd0, stall_cnt}, 32'd4);
        stall = 1'b0;

        // Valid JAL load carries jump and taken
        ex_valid = 1'b1; ex_jump = 2'b01; ex_taken = 1'b1;
        ex_memread = 1'b0; ex_memwrite = 1'b0; ex_regwrite = 1'b1; ex_memtoreg = 1'b0;
        step();
        check("jal_ctrl", ctrl_vec(), {24'd0, 8'b1100_0101});
        check("jal_bub", {28'd0, bubble_cnt}, 32'd2);

        // Stall counter saturation
        stall = 1'b1;
        step(20);
        check("stall_sat", {28'd0, stall_cnt}, 32'd15);
        check("stall_sat_valid", {31'd0, mem_valid}, 32'd1);
        cnt_clr = 1'b1;
        step();
        check("clr_stc", {28'd0, stall_cnt}, 32'd0);
        check("clr_bub", {28'd0, bubble_cnt}, 32'd0);
        cnt_clr = 1'b0; stall = 1'b0;

        // Bubble counter saturation
        flush = 1'b1;
        step(20);
        check("bub_sat", {28'd0, bubble_cnt}, 32'd15);
        check("bub_sat_stc", {28'd0, stall_cnt}, 32'd0);
        flush = 1'b0;

        // rst together with cnt_clr and stall
        stall = 1'b1;
        step();
        check("pre_rst_stc", {28'd0, stall_cnt}, 32'd1);
        rst = 1'b1; cnt_clr = 1'b1;
        step();
        check("rst_clr_cnts", {24'd0, stall_cnt, bubble_cnt}, 32'h0);
        check("rst_clr_ctrl", ctrl_vec(), 32'h0);
        check("rst_clr_alu", mem_alu_result, 32'h0);
        rst = 1'b0; cnt_clr = 1'b0; stall = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
